// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with valid/ready request and response channels.
// Define DMEM_CLEAR_EN to clear the whole array on reset; otherwise the array has no reset.
module data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [2:0]          lat_cnt;
  logic [31:0]         mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-3:0] word_addr;
  logic [1:0]            lane;
  logic [IDX_W-1:0]      mem_idx;
  logic                  size_err;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;
  logic                  accept;
  logic                  do_write;
  logic [3:0]            byte_en;
  logic [31:0]           wr_data;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           load_data;
  logic [31:0]           rsp_data_next;

  assign word_addr = req_addr[ADDR_WIDTH-1:2];
  assign lane      = req_addr[1:0];
  assign mem_idx   = word_addr[IDX_W-1:0];

  assign size_err     = (req_size == 2'b11);
  assign misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (lane != 2'b00));
  assign out_of_range = ({{(34 - ADDR_WIDTH){1'b0}}, word_addr} >= 32'(DEPTH_WORDS));
  assign req_err      = size_err || misaligned || out_of_range;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  // Qualify with rst_n so nothing reaches the unreset array while reset is held.
  assign do_write  = accept && req_we && !req_err && rst_n;

  // Byte enables and lane-replicated store data.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = req_wdata;
    case (req_size)
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      2'b10: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  assign rd_word = mem[mem_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'h0;
    case (req_size)
      2'b00:   load_data = {{24{~req_unsigned & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{~req_unsigned & rd_half[15]}}, rd_half};
      2'b10:   load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  assign rsp_data_next = (req_we || req_err) ? 32'h0 : load_data;

`ifdef DMEM_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH_WORDS; w++) mem[w] <= 32'h0;
    end else if (do_write) begin
      for (int l = 0; l < 4; l++)
        if (byte_en[l]) mem[mem_idx][8*l +: 8] <= wr_data[8*l +: 8];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int l = 0; l < 4; l++)
        if (byte_en[l]) mem[mem_idx][8*l +: 8] <= wr_data[8*l +: 8];
    end
  end
`endif

  // Response timing: WAIT enters RESP on the edge where the counter reaches 0,
  // so rsp_valid is first seen LATENCY cycles after the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_err   <= req_err;
            rsp_rdata <= rsp_data_next;
            lat_cnt   <= 3'(LATENCY - 1);
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: instance 0 (12-bit addr, LATENCY 1), instance 1 (13-bit addr, LATENCY 4).
module tb_data_memory_ctrl;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [12:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  exp_t        sbq [2][$];
  logic [7:0]  ref_mem [2][8192];
  int          fixed_delay [2];
  int          delay [2];
  int          held [2];
  bit          in_rsp [2];
  bit          post_hs [2];
  logic [31:0] snap_rd [2];
  logic        snap_err [2];

  data_memory_ctrl #(.ADDR_WIDTH(12), .DEPTH_WORDS(1024), .LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0][11:0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_memory_ctrl #(.ADDR_WIDTH(13), .DEPTH_WORDS(1024), .LATENCY(4)) dut_b (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int addr_mask(input int i);
    return (i == 0) ? 32'hFFF : 32'h1FFF;
  endfunction

  // Reference: byte array plus arithmetic extension, 1024 words per instance.
  function automatic void refModel(input int i, input bit we, input int size, input bit uns,
                                   input int addr, input logic [31:0] wdata,
                                   output logic [31:0] rd, output bit err);
    int n;
    longint v;
    n   = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    err = (size == 3) || (addr % n != 0) || (addr / 4 >= 1024);
    rd  = 32'h0;
    if (err) return;
    if (we) begin
      for (int b = 0; b < n; b++) ref_mem[i][addr + b] = wdata[8*b +: 8];
    end else begin
      v = 0;
      for (int b = 0; b < n; b++) v += longint'(ref_mem[i][addr + b]) << (8 * b);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      rd = v[31:0];
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no timely event, expected one within the bound (cycle %0d)", name, cyc);
  endtask

  task automatic applyStimulus(input int i, input bit we, input logic [1:0] size, input bit uns,
                               input int addr, input logic [31:0] wdata);
    exp_t        e;
    int          waited;
    logic [31:0] rd;
    bit          err;
    @(negedge clk);
    req_we[i]       = we;
    req_size[i]     = size;
    req_unsigned[i] = uns;
    req_addr[i]     = 13'(addr);
    req_wdata[i]    = wdata;
    req_valid[i]    = 1'b1;
    waited = 0;
    while (!req_ready[i] && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready[i]) begin
      failNow("req_ready timeout");
      req_valid[i] = 1'b0;
      return;
    end
    refModel(i, we, int'(size), uns, addr & addr_mask(i), wdata, rd, err);
    e.rd  = rd;
    e.err = err;
    e.acc = cyc + 1;
    sbq[i].push_back(e);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    req_addr[i]  = 13'($urandom);
    req_we[i]    = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while ((sbq[i].size() != 0 || post_hs[i]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) failNow("drain timeout");
  endtask

  // Monitor: compares each response against the head of the scoreboard and paces rsp_ready.
  initial begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      rsp_ready[i] = 1'b0;
      in_rsp[i] = 1'b0;
      post_hs[i] = 1'b0;
      held[i] = 0;
      delay[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n[i]) begin
          sbq[i].delete();
          in_rsp[i] = 1'b0;
          post_hs[i] = 1'b0;
          rsp_ready[i] = 1'b0;
        end else begin
          if (post_hs[i]) begin
            checkOutput("rsp_valid after handshake", 32'(rsp_valid[i]), 32'd0);
            checkOutput("req_ready after handshake", 32'(req_ready[i]), 32'd1);
            post_hs[i] = 1'b0;
          end
          if (rsp_valid[i]) begin
            if (!in_rsp[i]) begin
              if (sbq[i].size() == 0) begin
                failNow("unexpected response");
              end else begin
                e = sbq[i][0];
                checkOutput("rsp_rdata", rsp_rdata[i], e.rd);
                checkOutput("rsp_err", 32'(rsp_err[i]), 32'(e.err));
                checkOutput("latency", 32'(cyc - e.acc), 32'(lat_of(i) - 1));
                snap_rd[i]  = rsp_rdata[i];
                snap_err[i] = rsp_err[i];
                in_rsp[i]   = 1'b1;
                held[i]     = 0;
                delay[i]    = (fixed_delay[i] >= 0) ? fixed_delay[i] : $urandom_range(0, 3);
              end
            end else begin
              checkOutput("rsp_rdata held", rsp_rdata[i], snap_rd[i]);
              checkOutput("rsp_err held", 32'(rsp_err[i]), 32'(snap_err[i]));
            end
            checkOutput("req_ready while busy", 32'(req_ready[i]), 32'd0);
            if (!in_rsp[i] || held[i] >= delay[i]) begin
              rsp_ready[i] = 1'b1;
              if (in_rsp[i]) void'(sbq[i].pop_front());
              in_rsp[i]  = 1'b0;
              post_hs[i] = 1'b1;
            end else begin
              rsp_ready[i] = 1'b0;
              held[i]++;
            end
          end else begin
            rsp_ready[i] = 1'($urandom_range(0, 1));
            if (in_rsp[i]) begin
              failNow("rsp_valid dropped before handshake");
              in_rsp[i] = 1'b0;
              void'(sbq[i].pop_front());
            end else if (sbq[i].size() > 0 && cyc - sbq[i][0].acc > lat_of(i) + 8) begin
              failNow("response timeout");
              void'(sbq[i].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish before 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          i;
    int          a;
    logic [1:0]  sz;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k] = 1'b0;
      req_size[k] = 2'b00;
      req_unsigned[k] = 1'b0;
      req_addr[k] = 13'h0;
      req_wdata[k] = 32'h0;
      fixed_delay[k] = -1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset req_ready", 32'(req_ready[k]), 32'd1);
      checkOutput("reset rsp_valid", 32'(rsp_valid[k]), 32'd0);
      checkOutput("reset rsp_rdata", rsp_rdata[k], 32'h0);
      checkOutput("reset rsp_err", 32'(rsp_err[k]), 32'd0);
      rst_n[k] = 1'b1;
    end

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 64; w++) applyStimulus(k, 1'b1, 2'b10, 1'b0, w * 4, $urandom);
    drain(0);
    drain(1);

    // Word store/load, lane extraction, and partial store merge on instance 0.
    applyStimulus(0, 1, 2'b10, 0, 'h010, 32'hDEADBEEF);
    applyStimulus(0, 0, 2'b10, 0, 'h010, 32'h0);
    applyStimulus(0, 1, 2'b10, 0, 'h004, 32'h80817F80);
    applyStimulus(0, 0, 2'b00, 0, 'h005, 32'h0);
    applyStimulus(0, 0, 2'b00, 0, 'h006, 32'h0);
    applyStimulus(0, 0, 2'b00, 1, 'h007, 32'h0);
    applyStimulus(0, 0, 2'b01, 0, 'h006, 32'h0);
    applyStimulus(0, 0, 2'b01, 1, 'h004, 32'h0);
    applyStimulus(0, 1, 2'b10, 0, 'h020, 32'h11223344);
    applyStimulus(0, 1, 2'b00, 0, 'h021, 32'h000000AA);
    applyStimulus(0, 1, 2'b01, 0, 'h022, 32'h0000BBCC);
    applyStimulus(0, 0, 2'b10, 0, 'h020, 32'h0);
    applyStimulus(0, 0, 2'b01, 0, 'h003, 32'h0);
    applyStimulus(0, 1, 2'b10, 0, 'h002, 32'hFFFFFFFF);
    applyStimulus(0, 0, 2'b10, 0, 'h000, 32'h0);
    applyStimulus(0, 1, 2'b11, 0, 'h00C, 32'hFFFFFFFF);
    applyStimulus(0, 0, 2'b11, 0, 'h00C, 32'h0);
    applyStimulus(0, 0, 2'b10, 0, 'h00C, 32'h0);
    drain(0);

    // Out-of-range, held response, then reset during WAIT on instance 1.
    applyStimulus(1, 0, 2'b10, 0, 'h1000, 32'h0);
    applyStimulus(1, 1, 2'b10, 0, 'h1004, 32'h12345678);
    drain(1);
    fixed_delay[1] = 3;
    applyStimulus(1, 0, 2'b10, 0, 'h010, 32'h0);
    drain(1);
    fixed_delay[1] = -1;
    applyStimulus(1, 1, 2'b10, 0, 'h040, 32'h5A5A5A5A);
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    checkOutput("mid reset rsp_valid", 32'(rsp_valid[1]), 32'd0);
    rst_n[1] = 1'b1;
`ifdef DMEM_CLEAR_EN
    for (int b = 0; b < 8192; b++) ref_mem[1][b] = 8'h00;
`endif
    repeat (6) @(negedge clk);
    checkOutput("post reset req_ready", 32'(req_ready[1]), 32'd1);
    checkOutput("post reset rsp_valid", 32'(rsp_valid[1]), 32'd0);
    applyStimulus(1, 0, 2'b10, 0, 'h040, 32'h0);
    drain(1);

    for (int n = 0; n < 240; n++) begin
      i  = n % 2;
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'b01) ? 1 : (sz == 2'b10) ? 3 : 0);
      if (i == 1 && $urandom_range(0, 7) == 0) a = 'h1000 + $urandom_range(0, 255);
      applyStimulus(i, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    drain(0);
    drain(1);
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised, byte-addressed data memory for the memory stage, with a valid/ready request channel and a valid/ready response channel.
- Supports RISC-V load/store sizes (byte, half, word) with sign/zero extension, per-lane stores, alignment/range error reporting and a configurable response latency.
- Sits between the memory stage and writeback; one outstanding access at a time.

Parameters:
- ADDR_WIDTH, 12, byte-address width; word index = req_addr[ADDR_WIDTH-1:2].
- DEPTH_WORDS, 1024, number of 32-bit words; must be <= 2**(ADDR_WIDTH-2).
- LATENCY, 1, cycles from the acceptance edge to the first rsp_valid cycle; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, taken from the low bytes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal size or out-of-range access.

Behaviour:
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE).
- Acceptance: req_valid && req_ready at a rising edge.
- At the acceptance edge:
  - Classify the request.
  - Commit the store if legal.
  - Capture the extended load data into the response register.
  - Load the latency counter with LATENCY-1.
- State transitions:
  - IDLE -> RESP if LATENCY == 1; otherwise IDLE -> WAIT.
  - WAIT decrements the counter and moves to RESP after the counter reaches 0, so rsp_valid first rises exactly LATENCY cycles after the acceptance edge.
  - RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_valid && rsp_ready, then returns to IDLE. No back-to-back acceptance: the next request is accepted no earlier than the cycle after the response handshake.
- Error conditions, each setting rsp_err = 1:
  - req_size == 11.
  - Half with addr[0] != 0.
  - Word with addr[1:0] != 0.
  - Word index >= DEPTH_WORDS.
  - On error: no array write and rsp_rdata = 0. A response is still produced with normal latency.
- Stores:
  - Byte writes lane addr[1:0] with req_wdata[7:0].
  - Half writes lanes addr[1]*2 and addr[1]*2+1 with req_wdata[15:0].
  - Word writes all lanes.
  - Lanes not written are preserved.
  - Store response: rsp_rdata = 0.
- Loads:
  - Select the lane(s) by addr[1:0] and sign- or zero-extend to 32 bits per req_unsigned (ignored for word).
  - Read data reflects array contents before any same-edge write; none can occur, since only one access is in flight.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, counter 0.
- Reset mid-operation: an in-flight request is dropped with no response. A store already committed at its acceptance edge persists unless DMEM_CLEAR_EN is defined.
- Inputs other than req_valid are don't-care outside IDLE.

Optional Feature:
- Macro: DMEM_CLEAR_EN.
- Defined: asserting rst_n low clears every array word to 0 asynchronously with the control state.
- Undefined: the array has no reset and keeps its contents across reset, so it infers block RAM. Only control state and outputs reset.

Test Plan:
- LATENCY=1, SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_valid 1 cycle after each acceptance, rsp_rdata 0xDEADBEEF, rsp_err 0.
- Word 0x004 = 0x8081_7F80; LB 0x005 -> 0x0000007F; LB 0x006 -> 0xFFFFFF81; LBU 0x007 -> 0x00000080; LH 0x006 -> 0xFFFF8081; LHU 0x004 -> 0x00007F80.
- SW 0x020 0x11223344, SB 0x021 0xAA, SH 0x022 0xBBCC -> LW 0x020 returns 0xBBCCAA44.
- Error cases, each giving rsp_err 1, rsp_rdata 0, memory unchanged:
  - LH 0x003.
  - SW 0x002.
  - req_size 11.
  - ADDR_WIDTH=13, DEPTH_WORDS=1024, LW 0x1000.
- LATENCY=4 with rsp_ready held 0 for 3 cycles -> rsp_valid rises 4 cycles after acceptance, data stable while held, req_ready 0 until the cycle after the handshake.
- Assert rst_n during WAIT after SW 0x040 0x5A5A5A5A -> no response, req_ready 1. LW 0x040 returns 0x5A5A5A5A without DMEM_CLEAR_EN, 0x00000000 with it.
